drip_unit_counter: RTL and testbench

DRIP_UNIT_COUNTER -- requirements
Module: drip_unit_counter

---
 rtl/drip_unit_counter_if.sv | 29 ++
 rtl/drip_unit_counter.sv | 113 +++++++++++
 tb/tb_drip_unit_counter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/drip_unit_counter_if.sv
// drip_unit_counter_if: control levels in, BCD units digit and status pulses out.
`default_nettype none

interface drip_unit_counter_if;
  logic start;
  logic stop;
  logic hold;
  logic clear;
  logic A;
  logic B;
  logic C;
  logic D;
  logic carry;
  logic tick;
  logic running;
  logic paused;

  modport master (
    output start, stop, hold, clear,
    input  A, B, C, D, carry, tick, running, paused
  );

  modport slave (
    input  start, stop, hold, clear,
    output A, B, C, D, carry, tick, running, paused
  );
endinterface

`default_nettype wire

// File: rtl/drip_unit_counter.sv
// drip_unit_counter: prescaled BCD units stage with IDLE/RUN/PAUSE control.
// All outputs are registered; carry feeds the pulse input of the tens stage.
`default_nettype none

module drip_unit_counter #(
  parameter int PRESCALE = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  drip_unit_counter_if.slave bus
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PS_W-1:0] presc;
  logic [3:0]      units;
  logic            tick_q;
  logic            carry_q;
  logic            running_q;
  logic            paused_q;

  // clear never changes state by itself; stop outranks hold, hold outranks start
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (!bus.clear && !bus.stop && !bus.hold && bus.start)
          state_nxt = RUN;
        else
          state_nxt = IDLE;
      end
      RUN: begin
        if (bus.stop)
          state_nxt = IDLE;
        else if (bus.clear)
          state_nxt = RUN;
        else if (bus.hold)
          state_nxt = PAUSE;
        else
          state_nxt = RUN;
      end
      PAUSE: begin
        if (bus.stop)
          state_nxt = IDLE;
        else if (bus.clear || bus.hold)
          state_nxt = PAUSE;
        else
          state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      units     <= 4'd0;
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      running_q <= (state_nxt == RUN);
      paused_q  <= (state_nxt == PAUSE);
      tick_q    <= 1'b0;
      carry_q   <= 1'b0;

      if (bus.clear) begin
        presc <= '0;
        units <= 4'd0;
      end else if (state_nxt == IDLE) begin
        presc <= '0;
      end else if (state == RUN && state_nxt == RUN) begin
        // Only RUN->RUN edges count, so PAUSE->RUN resumes without losing phase
        if (presc == PS_LAST) begin
          presc  <= '0;
          tick_q <= 1'b1;
          if (units >= 4'd9) begin
            units   <= 4'd0;
            carry_q <= 1'b1;
          end else begin
            units <= units + 4'd1;
          end
        end else begin
          presc <= presc + PS_W'(1);
        end
      end
    end
  end

  assign bus.A       = units[3];
  assign bus.B       = units[2];
  assign bus.C       = units[1];
  assign bus.D       = units[0];
  assign bus.tick    = tick_q;
  assign bus.carry   = carry_q;
  assign bus.running = running_q;
  assign bus.paused  = paused_q;

endmodule

`default_nettype wire

// File: tb/tb_drip_unit_counter.sv
// tb_drip_unit_counter: directed scenarios plus random control traffic against a behavioural model.
`default_nettype none

module tb_drip_unit_counter;

  localparam int P = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  drip_unit_counter_if bus ();

  drip_unit_counter #(.PRESCALE(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: mode 0=idle 1=run 2=pause; digit is total increments since clear, mod 10
  int m_mode;
  int m_phase;
  int m_total;
  bit m_tick;

  function automatic logic [7:0] obs();
    return {bus.A, bus.B, bus.C, bus.D, bus.carry, bus.tick, bus.running, bus.paused};
  endfunction

  function automatic logic [7:0] model_out();
    logic [3:0] dig;
    dig = 4'(m_total % 10);
    return {dig, (m_tick && dig == 4'd0), m_tick, (m_mode == 1), (m_mode == 2)};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_total = 0; m_tick = 0;
  endtask

  task automatic model_edge();
    m_tick = 0;
    if (bus.clear) begin
      m_total = 0;
      m_phase = 0;
      if (bus.stop) m_mode = 0;
    end else if (bus.stop) begin
      m_mode  = 0;
      m_phase = 0;
    end else if (bus.hold) begin
      if (m_mode == 1) m_mode = 2;
    end else if (m_mode == 0) begin
      if (bus.start) m_mode = 1;
    end else if (m_mode == 2) begin
      m_mode = 1;
    end else begin
      m_phase++;
      if (m_phase == P) begin
        m_phase = 0;
        m_total++;
        m_tick = 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_edge(); else model_reset();
    @(negedge clk);
  endtask

  task automatic reset_dut();
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.clear = 0;
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_run();
    reset_dut();
    bus.start = 1;
    cyc();
    bus.start = 0;
  endtask

  task automatic test_reset();
    bus.start = 1; bus.stop = 0; bus.hold = 0; bus.clear = 0;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_err++; $display("FAIL reset_held: got %b expected %b", obs(), 8'h00);
    end
    bus.start = 0;
    reset = 1'b1;
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_err++; $display("FAIL reset_release: got %b expected %b", obs(), 8'h00);
    end
  endtask

  task automatic test_count();
    int ticks;
    start_run();
    ticks = 0;
    for (int e = 1; e <= 40; e++) begin
      cyc();
      if (bus.tick) ticks++;
      if (e == 4) begin
        n_cmp++;
        if (obs() !== {4'd1, 4'b0110}) begin
          n_err++; $display("FAIL count_edge4: got %b expected %b", obs(), {4'd1, 4'b0110});
        end
      end
      if (e == 36) begin
        n_cmp++;
        if (obs() !== {4'd9, 4'b0110}) begin
          n_err++; $display("FAIL count_edge36: got %b expected %b", obs(), {4'd9, 4'b0110});
        end
      end
      if (e == 40) begin
        n_cmp++;
        if (obs() !== {4'd0, 4'b1110}) begin
          n_err++; $display("FAIL count_wrap: got %b expected %b", obs(), {4'd0, 4'b1110});
        end
      end
    end
    cyc();
    n_cmp++;
    if (obs() !== {4'd0, 4'b0010}) begin
      n_err++; $display("FAIL count_carry_len: got %b expected %b", obs(), {4'd0, 4'b0010});
    end
    n_cmp++;
    if (ticks !== 10) begin
      n_err++; $display("FAIL count_ticks: got %0d expected 10", ticks);
    end
  endtask

  task automatic test_hold();
    start_run();
    repeat (6) cyc();
    bus.hold = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_cmp++;
      if (obs() !== {4'd1, 4'b0001}) begin
        n_err++; $display("FAIL hold_paused[%0d]: got %b expected %b", i, obs(), {4'd1, 4'b0001});
      end
    end
    bus.hold = 0;
    cyc();
    n_cmp++;
    if (obs() !== {4'd1, 4'b0010}) begin
      n_err++; $display("FAIL hold_resume: got %b expected %b", obs(), {4'd1, 4'b0010});
    end
    cyc();
    n_cmp++;
    if (obs() !== {4'd1, 4'b0010}) begin
      n_err++; $display("FAIL hold_run1: got %b expected %b", obs(), {4'd1, 4'b0010});
    end
    cyc();
    n_cmp++;
    if (obs() !== {4'd2, 4'b0110}) begin
      n_err++; $display("FAIL hold_run2: got %b expected %b", obs(), {4'd2, 4'b0110});
    end
  endtask

  task automatic test_clear();
    start_run();
    repeat (39) cyc();
    n_cmp++;
    if (obs() !== {4'd9, 4'b0010}) begin
      n_err++; $display("FAIL clear_pre: got %b expected %b", obs(), {4'd9, 4'b0010});
    end
    bus.clear = 1;
    cyc();
    bus.clear = 0;
    n_cmp++;
    if (obs() !== {4'd0, 4'b0010}) begin
      n_err++; $display("FAIL clear_terminal: got %b expected %b", obs(), {4'd0, 4'b0010});
    end
    repeat (3) cyc();
    n_cmp++;
    if (obs() !== {4'd0, 4'b0010}) begin
      n_err++; $display("FAIL clear_phase: got %b expected %b", obs(), {4'd0, 4'b0010});
    end
    cyc();
    n_cmp++;
    if (obs() !== {4'd1, 4'b0110}) begin
      n_err++; $display("FAIL clear_next_inc: got %b expected %b", obs(), {4'd1, 4'b0110});
    end
  endtask

  task automatic test_stop_start();
    start_run();
    repeat (5) cyc();
    bus.stop = 1; bus.hold = 1;
    cyc();
    n_cmp++;
    if (obs() !== {4'd1, 4'b0000}) begin
      n_err++; $display("FAIL stop_hold: got %b expected %b", obs(), {4'd1, 4'b0000});
    end
    bus.stop = 0; bus.start = 1;
    cyc();
    n_cmp++;
    if (obs() !== {4'd1, 4'b0000}) begin
      n_err++; $display("FAIL start_with_hold: got %b expected %b", obs(), {4'd1, 4'b0000});
    end
    bus.hold = 0;
    cyc();
    bus.start = 0;
    n_cmp++;
    if (obs() !== {4'd1, 4'b0010}) begin
      n_err++; $display("FAIL restart: got %b expected %b", obs(), {4'd1, 4'b0010});
    end
    repeat (3) cyc();
    n_cmp++;
    if (obs() !== {4'd1, 4'b0010}) begin
      n_err++; $display("FAIL restart_phase: got %b expected %b", obs(), {4'd1, 4'b0010});
    end
    cyc();
    n_cmp++;
    if (obs() !== {4'd2, 4'b0110}) begin
      n_err++; $display("FAIL restart_inc: got %b expected %b", obs(), {4'd2, 4'b0110});
    end
  endtask

  task automatic test_async_reset();
    bit found;
    start_run();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (bus.carry) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL async_wait_carry: got carry=0 expected carry=1 within 100 cycles");
    end else begin
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (obs() !== 8'h00) begin
        n_err++; $display("FAIL async_reset: got %b expected %b", obs(), 8'h00);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) cyc();
    n_cmp++;
    if (obs() !== 8'h00) begin
      n_err++; $display("FAIL idle_after_reset: got %b expected %b", obs(), 8'h00);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    reset_dut();
    for (int i = 0; i < 3000; i++) begin
      bus.start = 1'($urandom_range(1, 0));
      bus.stop  = ($urandom_range(15, 0) == 0);
      bus.hold  = ($urandom_range(3, 0) == 0);
      bus.clear = ($urandom_range(31, 0) == 0);
      cyc();
      exp = model_out();
      n_cmp++;
      if (obs() !== exp) begin
        n_err++; $display("FAIL random[%0d]: got %b expected %b", i, obs(), exp);
      end
    end
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.clear = 0;
  endtask

  initial begin
    bus.start = 0; bus.stop = 0; bus.hold = 0; bus.clear = 0;
    model_reset();
    test_reset();
    test_count();
    test_hold();
    test_clear();
    test_stop_start();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
